// File: rtl/types_pkg.sv
// Shared types and sizing for the ROB completion arbiter and its per-requester queues.
package types_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int NUM_CQ_REQ = 3;
  localparam int CQ_DEPTH   = 2;

  typedef logic [4:0] rob_tag_t;

  typedef enum logic [1:0] {
    CQ_ALU,
    CQ_MEM,
    CQ_BR
  } cq_req_e;

  // Round-robin successor in the fixed order alu -> mem -> br -> alu.
  function automatic cq_req_e rr_next(input cq_req_e r);
    case (r)
      CQ_ALU:  return CQ_MEM;
      CQ_MEM:  return CQ_BR;
      default: return CQ_ALU;
    endcase
  endfunction

endpackage

// File: rtl/rob_complete_arb_queue.sv
// Two-entry in-order completion queue with pop and per-slot squash; survivors are
// compacted toward slot 0 so slot 0 is always the head.
module complete_queue
  import types_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                push_i,
  input  rob_tag_t            push_tag_i,
  input  logic                pop_i,
  input  logic [CQ_DEPTH-1:0] squash_i,
  output logic                ready_o,
  output logic                head_vld_o,
  output rob_tag_t            head_tag_o,
  output rob_tag_t            next_tag_o,
  output logic [CQ_DEPTH-1:0] live_o
);

  logic [CQ_DEPTH-1:0] vld_q, vld_d;
  rob_tag_t            tag0_q, tag0_d;
  rob_tag_t            tag1_q, tag1_d;
  logic                keep0, keep1, push_ok;

  assign ready_o    = !(vld_q[0] && vld_q[1]);
  assign push_ok    = push_i && ready_o;
  assign keep0      = vld_q[0] && !pop_i && !squash_i[0];
  assign keep1      = vld_q[1] && !squash_i[1];
  assign head_vld_o = vld_q[0];
  assign head_tag_o = tag0_q;
  assign next_tag_o = tag1_q;
  assign live_o     = vld_q;

  always_comb begin
    vld_d  = '0;
    tag0_d = tag0_q;
    tag1_d = tag1_q;
    if (keep0) begin
      vld_d[0] = 1'b1;
      if (keep1) begin
        vld_d[1] = 1'b1;
      end else if (push_ok) begin
        vld_d[1] = 1'b1;
        tag1_d   = push_tag_i;
      end
    end else if (keep1) begin
      // Head left (popped or squashed): older survivor moves up, new entry goes behind it.
      vld_d[0] = 1'b1;
      tag0_d   = tag1_q;
      if (push_ok) begin
        vld_d[1] = 1'b1;
        tag1_d   = push_tag_i;
      end
    end else if (push_ok) begin
      vld_d[0] = 1'b1;
      tag0_d   = push_tag_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) vld_q <= '0;
    else       vld_q <= vld_d;
    tag0_q <= tag0_d;
    tag1_q <= tag1_d;
  end

endmodule

// File: rtl/rob_complete_arb.sv
// Round-robin arbiter draining three completion queues into the ROB, with
// age-based squash of wrong-path entries on a branch mispredict.
module rob_complete_arb
  import types_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_valid,
  input  logic [4:0] alu_tag,
  output logic       alu_ready,
  input  logic       mem_valid,
  input  logic [4:0] mem_tag,
  output logic       mem_ready,
  input  logic       br_valid,
  input  logic [4:0] br_tag,
  output logic       br_ready,
  input  logic       mispredict,
  input  logic [4:0] mispredict_tag,
  input  logic [4:0] rob_head,
  output logic       complete_in,
  output logic [4:0] rob_fu,
  output logic       pending
);

  logic [NUM_CQ_REQ-1:0] req_valid, req_ready, q_push, q_pop, head_vld;
  rob_tag_t              req_tag  [NUM_CQ_REQ];
  rob_tag_t              head_tag [NUM_CQ_REQ];
  rob_tag_t              next_tag [NUM_CQ_REQ];
  logic [CQ_DEPTH-1:0]   q_squash [NUM_CQ_REQ];
  logic [CQ_DEPTH-1:0]   q_live   [NUM_CQ_REQ];

  cq_req_e  rr_q, cand1, cand2, grant_idx;
  logic     grant_vld, grant_kill, grant_ok, complete_q;
  rob_tag_t grant_tag, rob_fu_q;
  logic     unused_tag_msb;

  // Age is distance from the retire pointer, modulo the 16-entry ROB.
  function automatic logic younger(input logic [3:0] t, input logic [3:0] br,
                                   input logic [3:0] head);
    logic [3:0] age_t, age_br;
    age_t  = t - head;
    age_br = br - head;
    return age_t > age_br;
  endfunction

  assign unused_tag_msb = ^{rob_head[4], mispredict_tag[4]};

  assign req_valid  = {br_valid, mem_valid, alu_valid};
  assign req_tag[0] = alu_tag;
  assign req_tag[1] = mem_tag;
  assign req_tag[2] = br_tag;
  assign alu_ready  = req_ready[0];
  assign mem_ready  = req_ready[1];
  assign br_ready   = req_ready[2];

  for (genvar i = 0; i < NUM_CQ_REQ; i++) begin : g_q
    // Wrong-path requests are still handshaken so the producer moves on, but never stored.
    assign q_push[i] = req_valid[i] && req_ready[i] &&
                       !(mispredict && younger(req_tag[i][3:0], mispredict_tag[3:0], rob_head[3:0]));
    assign q_pop[i]  = grant_vld && (int'(grant_idx) == i);
    assign q_squash[i] = {mispredict && younger(next_tag[i][3:0], mispredict_tag[3:0], rob_head[3:0]),
                          mispredict && younger(head_tag[i][3:0], mispredict_tag[3:0], rob_head[3:0])};

    complete_queue u_q (
      .clk        (clk),
      .reset      (reset),
      .push_i     (q_push[i]),
      .push_tag_i (req_tag[i]),
      .pop_i      (q_pop[i]),
      .squash_i   (q_squash[i]),
      .ready_o    (req_ready[i]),
      .head_vld_o (head_vld[i]),
      .head_tag_o (head_tag[i]),
      .next_tag_o (next_tag[i]),
      .live_o     (q_live[i])
    );
  end

  assign cand1 = rr_next(rr_q);
  assign cand2 = rr_next(cand1);

  always_comb begin
    grant_vld = 1'b1;
    grant_idx = rr_q;
    if (head_vld[rr_q])       grant_idx = rr_q;
    else if (head_vld[cand1]) grant_idx = cand1;
    else if (head_vld[cand2]) grant_idx = cand2;
    else                      grant_vld = 1'b0;
  end

  // A younger head granted in the flush cycle is popped and dropped, not completed.
  assign grant_tag  = head_tag[grant_idx];
  assign grant_kill = mispredict && younger(grant_tag[3:0], mispredict_tag[3:0], rob_head[3:0]);
  assign grant_ok   = grant_vld && !grant_kill;

  always_ff @(posedge clk) begin
    if (reset) begin
      complete_q <= 1'b0;
      rob_fu_q   <= '0;
      rr_q       <= CQ_ALU;
    end else begin
      complete_q <= grant_ok;
      rob_fu_q   <= grant_ok ? grant_tag : '0;
      if (grant_ok) rr_q <= rr_next(grant_idx);
    end
  end

  assign complete_in = complete_q;
  assign rob_fu      = rob_fu_q;
  assign pending     = |{q_live[0], q_live[1], q_live[2]};

endmodule

// File: tb/tb_rob_complete_arb.sv
// Bench for rob_complete_arb: hand vector table, directed corner sequences and
// randomized traffic compared against a queue-level reference model.
module tb_rob_complete_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_valid, mem_valid, br_valid;
  logic [4:0] alu_tag, mem_tag, br_tag;
  logic       alu_ready, mem_ready, br_ready;
  logic       mispredict;
  logic [4:0] mispredict_tag, rob_head;
  logic       complete_in;
  logic [4:0] rob_fu;
  logic       pending;

  always #5 clk = ~clk;

  rob_complete_arb dut (
    .clk            (clk),
    .reset          (reset),
    .alu_valid      (alu_valid),
    .alu_tag        (alu_tag),
    .alu_ready      (alu_ready),
    .mem_valid      (mem_valid),
    .mem_tag        (mem_tag),
    .mem_ready      (mem_ready),
    .br_valid       (br_valid),
    .br_tag         (br_tag),
    .br_ready       (br_ready),
    .mispredict     (mispredict),
    .mispredict_tag (mispredict_tag),
    .rob_head       (rob_head),
    .complete_in    (complete_in),
    .rob_fu         (rob_fu),
    .pending        (pending)
  );

  typedef struct {
    logic            rst;
    logic [2:0]      v;
    logic [2:0][4:0] t;
    logic            mp;
    logic [4:0]      mt;
    logic [4:0]      hd;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic       c;
    logic [4:0] fu;
    logic       pend;
    logic [2:0] rdy;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: one FIFO of tags per requester, pointer as 0..2.
  int         mq [3][$];
  int         rr_m = 0;
  logic       c_m  = 1'b0;
  logic [4:0] fu_m = '0;

  function automatic bit young(input int t, input int mt, input int hd);
    return ((t - hd) & 15) > ((mt - hd) & 15);
  endfunction

  function automatic stim_t mk(input bit rst, input bit [2:0] v, input int t0, input int t1,
                               input int t2, input bit mp, input int mt, input int hd);
    stim_t s;
    s.rst  = rst;
    s.v    = v;
    s.t[0] = 5'(t0);
    s.t[1] = 5'(t1);
    s.t[2] = 5'(t2);
    s.mp   = mp;
    s.mt   = 5'(mt);
    s.hd   = 5'(hd);
    return s;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_step(input stim_t s);
    bit rdy [3];
    int g;
    if (s.rst) begin
      for (int i = 0; i < 3; i++) mq[i].delete();
      rr_m = 0;
      c_m  = 1'b0;
      fu_m = '0;
      return;
    end
    for (int i = 0; i < 3; i++) rdy[i] = (mq[i].size() < 2);
    g = -1;
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (rr_m + k) % 3;
      if (g < 0 && mq[i].size() > 0) g = i;
    end
    c_m  = 1'b0;
    fu_m = '0;
    if (g >= 0) begin
      int ht;
      ht = mq[g].pop_front();
      if (!(s.mp && young(ht, s.mt, s.hd))) begin
        c_m  = 1'b1;
        fu_m = 5'(ht);
        rr_m = (g + 1) % 3;
      end
    end
    if (s.mp) begin
      for (int i = 0; i < 3; i++) begin
        int keep [$];
        foreach (mq[i][j]) if (!young(mq[i][j], s.mt, s.hd)) keep.push_back(mq[i][j]);
        mq[i] = keep;
      end
    end
    for (int i = 0; i < 3; i++)
      if (s.v[i] && rdy[i] && !(s.mp && young(s.t[i], s.mt, s.hd))) mq[i].push_back(s.t[i]);
  endtask

  // One clock: drive, step the model at the edge, then compare just after it.
  task automatic cycle(input stim_t s);
    reset          = s.rst;
    alu_valid      = s.v[0];
    mem_valid      = s.v[1];
    br_valid       = s.v[2];
    alu_tag        = s.t[0];
    mem_tag        = s.t[1];
    br_tag         = s.t[2];
    mispredict     = s.mp;
    mispredict_tag = s.mt;
    rob_head       = s.hd;
    @(posedge clk);
    model_step(s);
    #1;
    check("model_alu_ready", alu_ready, int'(mq[0].size() < 2));
    check("model_mem_ready", mem_ready, int'(mq[1].size() < 2));
    check("model_br_ready",  br_ready,  int'(mq[2].size() < 2));
    check("model_complete_in", complete_in, c_m);
    check("model_rob_fu", rob_fu, fu_m);
    check("model_pending", pending,
          int'(mq[0].size() + mq[1].size() + mq[2].size() > 0));
  endtask

  task automatic idle(input int hd);
    cycle(mk(0, 3'b000, 0, 0, 0, 0, 0, hd));
  endtask

  vec_t tbl [10];

  initial begin
    int p4, p5;

    // Single path (tag 3 through alu), then three-way contention from a fresh reset.
    tbl[0] = '{mk(1, 3'b000, 0, 0, 0, 0, 0, 0), 1'b0, 5'd0, 1'b0, 3'b111};
    tbl[1] = '{mk(0, 3'b001, 3, 0, 0, 0, 0, 0), 1'b0, 5'd0, 1'b1, 3'b111};
    tbl[2] = '{mk(0, 3'b000, 0, 0, 0, 0, 0, 0), 1'b1, 5'd3, 1'b0, 3'b111};
    tbl[3] = '{mk(0, 3'b000, 0, 0, 0, 0, 0, 0), 1'b0, 5'd0, 1'b0, 3'b111};
    tbl[4] = '{mk(1, 3'b000, 0, 0, 0, 0, 0, 0), 1'b0, 5'd0, 1'b0, 3'b111};
    tbl[5] = '{mk(0, 3'b111, 1, 2, 3, 0, 0, 0), 1'b0, 5'd0, 1'b1, 3'b111};
    tbl[6] = '{mk(0, 3'b000, 0, 0, 0, 0, 0, 0), 1'b1, 5'd1, 1'b1, 3'b111};
    tbl[7] = '{mk(0, 3'b000, 0, 0, 0, 0, 0, 0), 1'b1, 5'd2, 1'b1, 3'b111};
    tbl[8] = '{mk(0, 3'b000, 0, 0, 0, 0, 0, 0), 1'b1, 5'd3, 1'b0, 3'b111};
    tbl[9] = '{mk(0, 3'b000, 0, 0, 0, 0, 0, 0), 1'b0, 5'd0, 1'b0, 3'b111};

    foreach (tbl[i]) begin
      cycle(tbl[i].s);
      check($sformatf("tbl%0d_complete_in", i), complete_in, tbl[i].c);
      check($sformatf("tbl%0d_rob_fu", i), rob_fu, tbl[i].fu);
      check($sformatf("tbl%0d_pending", i), pending, tbl[i].pend);
      check($sformatf("tbl%0d_ready", i), {br_ready, mem_ready, alu_ready}, tbl[i].rdy);
    end

    // Backpressure: mem pushes 4 then 5 while alu and br keep offering work.
    cycle(mk(1, 3'b000, 0, 0, 0, 0, 0, 0));
    p4 = -1;
    p5 = -1;
    for (int k = 0; k < 20; k++) begin
      cycle(mk(0, {1'b1, (k < 2), 1'b1}, 8 + k % 8, 4 + k, 16 + k % 8, 0, 0, 0));
      if (k == 1) check("bp_mem_ready_full", mem_ready, 0);
      if (complete_in && rob_fu == 5'd4 && p4 < 0) p4 = k;
      if (complete_in && rob_fu == 5'd5 && p5 < 0) p5 = k;
    end
    check("bp_tag4_retired", int'(p4 >= 0), 1);
    check("bp_4_before_5", int'(p5 > p4 && p4 >= 0), 1);

    // Wrap-around flush: head 14, queued 15/0/1, branch 15.
    cycle(mk(1, 3'b000, 0, 0, 0, 0, 0, 14));
    cycle(mk(0, 3'b111, 15, 0, 1, 0, 0, 14));
    cycle(mk(0, 3'b000, 0, 0, 0, 1, 15, 14));
    check("wrap_complete_in", complete_in, 1);
    check("wrap_rob_fu", rob_fu, 15);
    check("wrap_pending", pending, 0);
    for (int k = 0; k < 3; k++) begin
      idle(14);
      check($sformatf("wrap_quiet%0d", k), complete_in, 0);
    end

    // Flush kills the granted alu head; pointer must still favour alu afterwards.
    cycle(mk(1, 3'b000, 0, 0, 0, 0, 0, 2));
    cycle(mk(0, 3'b001, 6, 0, 0, 0, 0, 2));
    cycle(mk(0, 3'b000, 0, 0, 0, 1, 5, 2));
    check("fg_complete_in", complete_in, 0);
    check("fg_pending", pending, 0);
    cycle(mk(0, 3'b011, 8, 9, 0, 0, 0, 2));
    idle(2);
    check("fg_rr_first", rob_fu, 8);
    idle(2);
    check("fg_rr_second", rob_fu, 9);

    // Reset in the middle of saturated traffic, with a mispredict and pushes alongside.
    cycle(mk(1, 3'b000, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++) cycle(mk(0, 3'b111, k, 8 + k, 16 + k, 0, 0, 0));
    check("rm_before_pending", pending, 1);
    cycle(mk(1, 3'b111, 1, 2, 3, 1, 0, 0));
    check("rm_ready", {br_ready, mem_ready, alu_ready}, 3'b111);
    check("rm_pending", pending, 0);
    check("rm_complete_in", complete_in, 0);
    idle(0);
    check("rm_after_complete_in", complete_in, 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      stim_t s;
      s.rst  = ($urandom_range(99) < 2);
      s.v    = 3'($urandom);
      s.t[0] = 5'($urandom);
      s.t[1] = 5'($urandom);
      s.t[2] = 5'($urandom);
      s.mp   = ($urandom_range(9) == 0);
      s.mt   = 5'($urandom);
      s.hd   = 5'($urandom_range(31));
      cycle(s);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
